// File: rtl/fft_bitrev_reorder.sv
// Single-buffered frame reorder ahead of the FFT butterflies: a full frame of
// N = 2**ADDR_W samples is written in natural order and read back in bit-reversed order.
module fft_bitrev_reorder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_first_o,
  output logic              out_last_o,
  output logic              busy_o
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_MAX  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_PRIME = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem_q [N];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] out_data_q;

  logic              accept_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;

  // Next-state, counter and RAM-port control
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    rd_addr_s   = bitrev(CNT_ZERO);
    in_ready_o  = (state_q == S_LOAD) && !rst_i;
    accept_s    = in_valid_i && in_ready_o;

    case (state_q)
      S_LOAD: begin
        if (accept_s) begin
          wr_en_s  = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          if (wr_cnt_q == CNT_MAX) begin
            state_d = S_PRIME;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      S_PRIME: begin
        rd_en_s     = 1'b1;
        rd_addr_s   = bitrev(CNT_ZERO);
        out_valid_d = 1'b1;
        rd_cnt_d    = CNT_ZERO;
        state_d     = S_DRAIN;
      end
      S_DRAIN: begin
        // A stalled handshake leaves everything untouched so the sample is held.
        if (out_valid_q && out_ready_i) begin
          if (rd_cnt_q == CNT_MAX) begin
            out_valid_d = 1'b0;
            rd_cnt_d    = CNT_ZERO;
            state_d     = S_LOAD;
          end else begin
            rd_cnt_d  = rd_cnt_q + CNT_ONE;
            rd_en_s   = 1'b1;
            rd_addr_s = bitrev(rd_cnt_q + CNT_ONE);
          end
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: begin
        state_d     = S_LOAD;
        wr_cnt_d    = CNT_ZERO;
        rd_cnt_d    = CNT_ZERO;
        out_valid_d = 1'b0;
      end
    endcase

    out_first_d = out_valid_d && (rd_cnt_d == CNT_ZERO);
    out_last_d  = out_valid_d && (rd_cnt_d == CNT_MAX);
    busy_d      = (state_d != S_LOAD) || (wr_cnt_d != CNT_ZERO);
  end

  // Control/status registers and the synchronous RAM read port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= CNT_ZERO;
      rd_cnt_q    <= CNT_ZERO;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      if (rd_en_s) begin
        out_data_q <= mem_q[rd_addr_s];
      end
    end
  end

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_cnt_q] <= in_data_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_first_o = out_first_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomised self-checking bench for fft_bitrev_reorder: an 8-point instance for
// handshake scenarios and a 256-point instance for the default-size ordering.
module tb_fft_bitrev_reorder;

  typedef logic [31:0] frame_t [8];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3, iv3, ir3, ov3, or3, of3, ol3, busy3;
  logic [31:0] id3, od3;
  logic        rst8, iv8, ir8, ov8, or8, of8, ol8, busy8;
  logic [31:0] id8, od8;

  fft_bitrev_reorder #(.ADDR_W(3), .DATA_W(32)) dut3 (
    .clk_i(clk), .rst_i(rst3), .in_valid_i(iv3), .in_ready_o(ir3), .in_data_i(id3),
    .out_valid_o(ov3), .out_ready_i(or3), .out_data_o(od3),
    .out_first_o(of3), .out_last_o(ol3), .busy_o(busy3)
  );

  fft_bitrev_reorder #(.ADDR_W(8), .DATA_W(32)) dut8 (
    .clk_i(clk), .rst_i(rst8), .in_valid_i(iv8), .in_ready_o(ir8), .in_data_i(id8),
    .out_valid_o(ov8), .out_ready_i(or8), .out_data_o(od8),
    .out_first_o(of8), .out_last_o(ol8), .busy_o(busy8)
  );

  int ncmp = 0;
  int nfail = 0;

  bit          l_ok;
  logic [31:0] d_got[$];
  int          d_flag_bad, d_valid_cycles, d_gaps, d_ir_hi, d_stall_bad, d_stall_cycles;
  bit          d_ok;
  logic        d_first_ov;
  logic [31:0] d_first_stall_od;
  bit          d_use_hold = 1'b0;
  logic [31:0] d_hold = 32'd0;

  // Reference: reverse the low 'bits' binary digits of j by repeated division
  function automatic int bitrev_ref(input int j, input int bits);
    int r = 0;
    int x = j;
    for (int k = 0; k < bits; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic model3(input frame_t v, output frame_t e);
    for (int j = 0; j < 8; j++) e[j] = v[bitrev_ref(j, 3)];
  endtask

  task automatic load3(input frame_t v, input int pct, input int start);
    int acc = start;
    int cyc = 0;
    while (acc < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (int'($urandom_range(99)) < pct) begin
        iv3 = 1'b1;
        id3 = v[acc];
      end else begin
        iv3 = 1'b0;
        id3 = $urandom;
      end
      if (iv3 && ir3) acc++;
    end
    l_ok = (acc == 8);
  endtask

  // mode 0: always ready; 1: 5-cycle stall at position 2 then 1/0 alternation; 2: random
  task automatic drain3(input int mode, input bit force_iv, input int stop_after);
    int cyc = 0;
    int hs = 0;
    int stall_cnt = 0;
    bit alt = 1'b1;
    bit prev_stalled = 1'b0;
    bit got_stall = 1'b0;
    bit r;
    logic [31:0] prev_od = 32'd0;
    d_got.delete();
    d_flag_bad = 0; d_valid_cycles = 0; d_gaps = 0; d_ir_hi = 0;
    d_stall_bad = 0; d_stall_cycles = 0; d_ok = 1'b0;
    d_first_ov = 1'bx; d_first_stall_od = 32'hxxxx_xxxx;
    while (cyc < 400) begin
      @(negedge clk);
      if (cyc == 0) d_first_ov = ov3;
      cyc++;
      if (prev_stalled && (ov3 !== 1'b1 || od3 !== prev_od)) d_stall_bad++;
      case (mode)
        0: r = 1'b1;
        1: begin
          if (hs < 2) r = 1'b1;
          else if (stall_cnt < 5) begin r = 1'b0; stall_cnt++; end
          else begin r = alt; alt = ~alt; end
        end
        2: r = ($urandom_range(99) < 60);
        default: r = 1'b1;
      endcase
      or3 = r;
      if (force_iv) begin
        iv3 = 1'b1;
        id3 = d_use_hold ? d_hold : $urandom;
      end else begin
        iv3 = 1'b0;
      end
      if (ov3 === 1'b1) begin
        d_valid_cycles++;
        if (ir3 !== 1'b0) d_ir_hi++;
        if (of3 !== (hs == 0) || ol3 !== (hs == 7)) d_flag_bad++;
      end else begin
        if (d_got.size() > 0) d_gaps++;
        if (of3 !== 1'b0 || ol3 !== 1'b0) d_flag_bad++;
      end
      prev_stalled = (ov3 === 1'b1) && !r;
      if (prev_stalled) begin
        d_stall_cycles++;
        if (!got_stall) begin got_stall = 1'b1; d_first_stall_od = od3; end
      end
      prev_od = od3;
      if (ov3 === 1'b1 && r) begin
        d_got.push_back(od3);
        hs++;
        if (hs == 8 || hs == stop_after) begin d_ok = 1'b1; break; end
      end
    end
  endtask

  task automatic test_reset();
    rst3 = 1'b1; rst8 = 1'b1; iv3 = 1'b0; iv8 = 1'b0; or3 = 1'b0; or8 = 1'b0;
    id3 = 32'd0; id8 = 32'd0;
    repeat (3) @(negedge clk);
    ncmp++; if (ir3 !== 1'b0) begin nfail++; $display("FAIL reset_in_ready3 got=%b exp=0", ir3); end
    ncmp++; if (ov3 !== 1'b0) begin nfail++; $display("FAIL reset_out_valid3 got=%b exp=0", ov3); end
    ncmp++; if (od3 !== 32'd0) begin nfail++; $display("FAIL reset_out_data3 got=%h exp=0", od3); end
    ncmp++; if (busy3 !== 1'b0) begin nfail++; $display("FAIL reset_busy3 got=%b exp=0", busy3); end
    ncmp++; if (of3 !== 1'b0 || ol3 !== 1'b0) begin nfail++; $display("FAIL reset_flags3 got=%b%b exp=00", of3, ol3); end
    ncmp++; if (ir8 !== 1'b0 || ov8 !== 1'b0 || busy8 !== 1'b0) begin
      nfail++; $display("FAIL reset_dut8 got ir=%b ov=%b busy=%b exp=000", ir8, ov8, busy8);
    end
    rst3 = 1'b0; rst8 = 1'b0;
    #1;
    ncmp++; if (ir3 !== 1'b1 || ir8 !== 1'b1) begin nfail++; $display("FAIL post_reset_ready got=%b%b exp=11", ir3, ir8); end
  endtask

  task automatic test_natural();
    frame_t v, e;
    for (int i = 0; i < 8; i++) v[i] = i;
    model3(v, e);
    load3(v, 100, 0);
    ncmp++; if (!l_ok) begin nfail++; $display("FAIL t1_load_timeout got=0 exp=1"); end
    drain3(0, 1'b0, 8);
    ncmp++; if (d_first_ov !== 1'b0) begin nfail++; $display("FAIL t1_prime_valid got=%b exp=0", d_first_ov); end
    ncmp++; if (!d_ok || d_got.size() != 8) begin nfail++; $display("FAIL t1_count got=%0d exp=8", d_got.size()); end
    for (int j = 0; j < 8 && j < d_got.size(); j++) begin
      ncmp++; if (d_got[j] !== e[j]) begin nfail++; $display("FAIL t1_data pos%0d got=%0d exp=%0d", j, d_got[j], e[j]); end
    end
    ncmp++; if (d_flag_bad != 0) begin nfail++; $display("FAIL t1_first_last got=%0d bad exp=0", d_flag_bad); end
    ncmp++; if (d_valid_cycles != 8 || d_gaps != 0) begin
      nfail++; $display("FAIL t1_throughput got=%0d valid %0d gaps exp=8 valid 0 gaps", d_valid_cycles, d_gaps);
    end
    @(negedge clk);
    iv3 = 1'b0;
    ncmp++; if (ir3 !== 1'b1 || ov3 !== 1'b0) begin nfail++; $display("FAIL t1_return_load got ir=%b ov=%b exp ir=1 ov=0", ir3, ov3); end
  endtask

  task automatic test_stall();
    frame_t v, e;
    for (int i = 0; i < 8; i++) v[i] = i;
    model3(v, e);
    load3(v, 100, 0);
    ncmp++; if (!l_ok) begin nfail++; $display("FAIL t3_load_timeout got=0 exp=1"); end
    drain3(1, 1'b0, 8);
    ncmp++; if (!d_ok || d_got.size() != 8) begin nfail++; $display("FAIL t3_count got=%0d exp=8", d_got.size()); end
    for (int j = 0; j < 8 && j < d_got.size(); j++) begin
      ncmp++; if (d_got[j] !== e[j]) begin nfail++; $display("FAIL t3_data pos%0d got=%0d exp=%0d", j, d_got[j], e[j]); end
    end
    ncmp++; if (d_stall_bad != 0) begin nfail++; $display("FAIL t3_hold got=%0d changes exp=0", d_stall_bad); end
    ncmp++; if (d_first_stall_od !== e[2]) begin nfail++; $display("FAIL t3_stall_value got=%0d exp=%0d", d_first_stall_od, e[2]); end
    ncmp++; if (d_stall_cycles != 10) begin nfail++; $display("FAIL t3_stall_cycles got=%0d exp=10", d_stall_cycles); end
    ncmp++; if (d_flag_bad != 0) begin nfail++; $display("FAIL t3_first_last got=%0d bad exp=0", d_flag_bad); end
    @(negedge clk);
    or3 = 1'b0;
  endtask

  task automatic test_gaps();
    frame_t v, e;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) v[i] = $urandom;
      model3(v, e);
      load3(v, 50, 0);
      ncmp++; if (!l_ok) begin nfail++; $display("FAIL t4_load_timeout f%0d got=0 exp=1", f); end
      drain3(0, 1'b1, 8);
      ncmp++; if (d_ir_hi != 0) begin nfail++; $display("FAIL t4_ready_in_drain f%0d got=%0d exp=0", f, d_ir_hi); end
      ncmp++; if (!d_ok || d_got.size() != 8) begin nfail++; $display("FAIL t4_count f%0d got=%0d exp=8", f, d_got.size()); end
      for (int j = 0; j < 8 && j < d_got.size(); j++) begin
        ncmp++; if (d_got[j] !== e[j]) begin nfail++; $display("FAIL t4_data f%0d pos%0d got=%h exp=%h", f, j, d_got[j], e[j]); end
      end
      @(negedge clk);
      iv3 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    frame_t v, e;
    for (int i = 0; i < 8; i++) v[i] = $urandom;
    load3(v, 100, 0);
    drain3(0, 1'b0, 3);
    ncmp++; if (!d_ok) begin nfail++; $display("FAIL t5_partial_drain got=0 exp=1"); end
    @(negedge clk);
    ncmp++; if (busy3 !== 1'b1) begin nfail++; $display("FAIL t5_busy_before got=%b exp=1", busy3); end
    rst3 = 1'b1; iv3 = 1'b0; or3 = 1'b0;
    #1;
    ncmp++; if (ir3 !== 1'b0) begin nfail++; $display("FAIL t5_ready_in_reset got=%b exp=0", ir3); end
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    ncmp++; if (ov3 !== 1'b0 || ir3 !== 1'b1 || busy3 !== 1'b0) begin
      nfail++; $display("FAIL t5_after_reset got ov=%b ir=%b busy=%b exp 0 1 0", ov3, ir3, busy3);
    end
    for (int i = 0; i < 8; i++) v[i] = 10 + i;
    model3(v, e);
    load3(v, 100, 0);
    drain3(0, 1'b0, 8);
    ncmp++; if (!d_ok || d_got.size() != 8) begin nfail++; $display("FAIL t5_count got=%0d exp=8", d_got.size()); end
    for (int j = 0; j < 8 && j < d_got.size(); j++) begin
      ncmp++; if (d_got[j] !== e[j]) begin nfail++; $display("FAIL t5_data pos%0d got=%0d exp=%0d", j, d_got[j], e[j]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2, e1, e2;
    int acc0;
    for (int i = 0; i < 8; i++) begin f1[i] = $urandom; f2[i] = $urandom; end
    model3(f1, e1);
    model3(f2, e2);
    load3(f1, 100, 0);
    d_use_hold = 1'b1;
    d_hold = f2[0];
    drain3(0, 1'b1, 8);
    d_use_hold = 1'b0;
    ncmp++; if (d_ir_hi != 0) begin nfail++; $display("FAIL t6_ready_in_drain got=%0d exp=0", d_ir_hi); end
    for (int j = 0; j < 8 && j < d_got.size(); j++) begin
      ncmp++; if (d_got[j] !== e1[j]) begin nfail++; $display("FAIL t6_frame1 pos%0d got=%h exp=%h", j, d_got[j], e1[j]); end
    end
    @(negedge clk);
    iv3 = 1'b1;
    id3 = f2[0];
    ncmp++; if (ir3 !== 1'b1) begin nfail++; $display("FAIL t6_ready_rise got=%b exp=1", ir3); end
    acc0 = (ir3 === 1'b1) ? 1 : 0;
    load3(f2, 100, acc0);
    drain3(0, 1'b0, 8);
    ncmp++; if (!d_ok || d_got.size() != 8) begin nfail++; $display("FAIL t6_count got=%0d exp=8", d_got.size()); end
    for (int j = 0; j < 8 && j < d_got.size(); j++) begin
      ncmp++; if (d_got[j] !== e2[j]) begin nfail++; $display("FAIL t6_frame2 pos%0d got=%h exp=%h", j, d_got[j], e2[j]); end
    end
    @(negedge clk);
    iv3 = 1'b0;
  endtask

  task automatic test_random();
    frame_t v, e;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) v[i] = $urandom;
      model3(v, e);
      load3(v, 70, 0);
      drain3(2, 1'b0, 8);
      ncmp++; if (!d_ok || d_got.size() != 8) begin nfail++; $display("FAIL rnd_count f%0d got=%0d exp=8", f, d_got.size()); end
      for (int j = 0; j < 8 && j < d_got.size(); j++) begin
        ncmp++; if (d_got[j] !== e[j]) begin nfail++; $display("FAIL rnd_data f%0d pos%0d got=%h exp=%h", f, j, d_got[j], e[j]); end
      end
      ncmp++; if (d_stall_bad != 0 || d_flag_bad != 0) begin
        nfail++; $display("FAIL rnd_hold_flags f%0d got=%0d/%0d exp=0/0", f, d_stall_bad, d_flag_bad);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_large();
    logic [31:0] got[$];
    int acc = 0;
    int cyc = 0;
    bit flags_ok = 1'b1;
    while (acc < 256 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      iv8 = 1'b1;
      id8 = acc;
      if (ir8) acc++;
    end
    ncmp++; if (acc != 256) begin nfail++; $display("FAIL t2_load got=%0d exp=256", acc); end
    cyc = 0;
    while (got.size() < 256 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      iv8 = 1'b0;
      or8 = 1'b1;
      if (ov8 === 1'b1) begin
        if (of8 !== (got.size() == 0) || ol8 !== (got.size() == 255)) flags_ok = 1'b0;
        got.push_back(od8);
      end
    end
    ncmp++; if (got.size() != 256) begin nfail++; $display("FAIL t2_count got=%0d exp=256", got.size()); end
    for (int j = 0; j < 256 && j < got.size(); j++) begin
      ncmp++; if (got[j] !== bitrev_ref(j, 8)) begin nfail++; $display("FAIL t2_data pos%0d got=%0d exp=%0d", j, got[j], bitrev_ref(j, 8)); end
    end
    if (got.size() == 256) begin
      ncmp++; if (got[1] !== 32'd128 || got[2] !== 32'd64 || got[3] !== 32'd192 || got[255] !== 32'd255) begin
        nfail++; $display("FAIL t2_landmarks got=%0d,%0d,%0d,%0d exp=128,64,192,255", got[1], got[2], got[3], got[255]);
      end
    end
    ncmp++; if (!flags_ok) begin nfail++; $display("FAIL t2_first_last got=bad exp=ok"); end
    @(negedge clk);
    or8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_natural();
    test_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_large();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
